err_event_rx: RTL



---
 rtl/err_event_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/err_event_rx.sv
// Receive side of the residue-channel error-flag path: regenerates the registered any-error
// output and queues timestamped source masks for the controller, with sticky/counter status.
module err_event_rx #(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DROP_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       inA,
  input  logic                       inB,
  input  logic                       inC,
  input  logic                       clr,
  output logic                       err_any,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [2:0]                 ev_mask,
  output logic [TS_W-1:0]            ev_ts,
  output logic [2:0]                 sticky,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [TS_W-1:0]   ts_q;
  logic [2:0]        s1_mask_q;
  logic [TS_W-1:0]   s1_ts_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [2:0]        sticky_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic [2:0]        mem_mask [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];

  logic event_s2, full, pop, push, drop;

  always_comb begin
    event_s2 = |s1_mask_q;
    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) && ev_ready && !clr;
    // A full FIFO still accepts when the head leaves on the same edge.
    push     = event_s2 && !clr && (!full || pop);
    drop     = event_s2 && !clr && full && !pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      s1_mask_q  <= '0;
      s1_ts_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sticky_q   <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q      <= ts_q + 1'b1;
      s1_mask_q <= {inC, inB, inA};
      s1_ts_q   <= ts_q;
      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        sticky_q   <= '0;
        err_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
        if (event_s2) begin
          sticky_q <= sticky_q | s1_mask_q;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
        if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_mask[wr_ptr_q] <= s1_mask_q;
      mem_ts[wr_ptr_q]   <= s1_ts_q;
    end
  end

  assign err_any    = |s1_mask_q;
  assign ev_valid   = (level_q != '0);
  assign ev_mask    = ev_valid ? mem_mask[rd_ptr_q] : 3'b000;
  assign ev_ts      = ev_valid ? mem_ts[rd_ptr_q] : '0;
  assign sticky     = sticky_q;
  assign err_cnt    = err_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule
